// File: rtl/axilite_gpio_out.sv
// AXI4-Lite slave driving a bank of registered GPIO outputs.
// Registers (selected by address bits [3:2]): 0x0 DATA (RW), 0x4 SET (W1S),
// 0x8 CLR (W1C), 0xC unmapped (SLVERR). Read and write channels are independent.
//
// Write FSM
//   state  | meaning
//   IDLE   | waiting for AW and W (both ready)
//   GOT_AW | address latched, waiting for W
//   GOT_W  | data/strobes latched, waiting for AW
//   RESP   | register updated, bvalid held until bready
// Read FSM
//   state  | meaning
//   R_IDLE | waiting for AR
//   R_DATA | rdata/rresp registered, rvalid held until rready
module axilite_gpio_out #(
    parameter int NUM_GPIO_OUT = 1,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    s_axilite_awvalid_i,
    output logic                    s_axilite_awready_o,
    input  logic [ADDR_WIDTH-1:0]   s_axilite_awaddr_i,
    input  logic                    s_axilite_wvalid_i,
    output logic                    s_axilite_wready_o,
    input  logic [31:0]             s_axilite_wdata_i,
    input  logic [3:0]              s_axilite_wstrb_i,
    output logic                    s_axilite_bvalid_o,
    input  logic                    s_axilite_bready_i,
    output logic [1:0]              s_axilite_bresp_o,
    input  logic                    s_axilite_arvalid_i,
    output logic                    s_axilite_arready_o,
    input  logic [ADDR_WIDTH-1:0]   s_axilite_araddr_i,
    output logic                    s_axilite_rvalid_o,
    input  logic                    s_axilite_rready_i,
    output logic [31:0]             s_axilite_rdata_o,
    output logic [1:0]              s_axilite_rresp_o,
    output logic [NUM_GPIO_OUT-1:0] gpio_o
);

    typedef enum logic [1:0] {IDLE, GOT_AW, GOT_W, RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    localparam logic [1:0] SEL_DATA = 2'd0;
    localparam logic [1:0] SEL_SET  = 2'd1;
    localparam logic [1:0] SEL_CLR  = 2'd2;
    localparam logic [1:0] SEL_NONE = 2'd3;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    logic                    aw_hs, w_hs, ar_hs, wr_commit;
    logic [1:0]              aw_sel_q, eff_sel;
    logic [31:0]             wdata_q, eff_data, lane_mask, wbits32, rd_ext;
    logic [3:0]              wstrb_q, eff_strb;
    logic [NUM_GPIO_OUT-1:0] gpio_q, gpio_next, mask, wbits;
    logic [1:0]              bresp_q, rresp_q;
    logic [31:0]             rdata_q;
    logic                    unused_bits;

    // Upper address bits and the lane bits above the GPIO width are don't-care.
    assign unused_bits = ^{s_axilite_awaddr_i, s_axilite_araddr_i, wbits32, lane_mask};

    // Write FSM state register
    always_ff @(posedge clock_i) begin
        if (reset_i) wr_state <= IDLE;
        else         wr_state <= wr_next;
    end

    // Write FSM next state, ready/valid outputs and handshakes
    always_comb begin
        wr_next             = wr_state;
        s_axilite_awready_o = 1'b0;
        s_axilite_wready_o  = 1'b0;
        s_axilite_bvalid_o  = 1'b0;
        case (wr_state)
            IDLE: begin
                s_axilite_awready_o = 1'b1;
                s_axilite_wready_o  = 1'b1;
            end
            GOT_AW:  s_axilite_wready_o  = 1'b1;
            GOT_W:   s_axilite_awready_o = 1'b1;
            default: s_axilite_bvalid_o  = 1'b1;
        endcase
        // Readies must read 0 throughout reset even once the FSM sits in IDLE.
        if (reset_i) begin
            s_axilite_awready_o = 1'b0;
            s_axilite_wready_o  = 1'b0;
        end
        aw_hs = s_axilite_awvalid_i & s_axilite_awready_o;
        w_hs  = s_axilite_wvalid_i & s_axilite_wready_o;
        case (wr_state)
            IDLE: begin
                if (aw_hs && w_hs) wr_next = RESP;
                else if (aw_hs)    wr_next = GOT_AW;
                else if (w_hs)     wr_next = GOT_W;
            end
            GOT_AW:  if (w_hs)  wr_next = RESP;
            GOT_W:   if (aw_hs) wr_next = RESP;
            default: if (s_axilite_bready_i) wr_next = IDLE;
        endcase
        wr_commit = (wr_state != RESP) && (wr_next == RESP);
    end

    // Merge live and latched halves of the write, then apply the byte-lane update
    always_comb begin
        eff_sel   = (wr_state == GOT_AW) ? aw_sel_q : s_axilite_awaddr_i[3:2];
        eff_data  = (wr_state == GOT_W)  ? wdata_q  : s_axilite_wdata_i;
        eff_strb  = (wr_state == GOT_W)  ? wstrb_q  : s_axilite_wstrb_i;
        lane_mask = {{8{eff_strb[3]}}, {8{eff_strb[2]}}, {8{eff_strb[1]}}, {8{eff_strb[0]}}};
        wbits32   = eff_data & lane_mask;
        mask      = lane_mask[NUM_GPIO_OUT-1:0];
        wbits     = wbits32[NUM_GPIO_OUT-1:0];
        case (eff_sel)
            SEL_DATA: gpio_next = (gpio_q & ~mask) | wbits;
            SEL_SET:  gpio_next = gpio_q | wbits;
            SEL_CLR:  gpio_next = gpio_q & ~wbits;
            default:  gpio_next = gpio_q;
        endcase
    end

    // Latch partial AW/W halves; commit register and response on entry to RESP
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            aw_sel_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            gpio_q   <= '0;
            bresp_q  <= RESP_OKAY;
        end else begin
            if (aw_hs) aw_sel_q <= s_axilite_awaddr_i[3:2];
            if (w_hs) begin
                wdata_q <= s_axilite_wdata_i;
                wstrb_q <= s_axilite_wstrb_i;
            end
            if (wr_commit) begin
                gpio_q  <= gpio_next;
                bresp_q <= (eff_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // Read FSM state register
    always_ff @(posedge clock_i) begin
        if (reset_i) rd_state <= R_IDLE;
        else         rd_state <= rd_next;
    end

    // Read FSM next state and handshake outputs
    always_comb begin
        rd_next             = rd_state;
        s_axilite_arready_o = (rd_state == R_IDLE) && !reset_i;
        s_axilite_rvalid_o  = (rd_state == R_DATA);
        ar_hs               = s_axilite_arvalid_i & s_axilite_arready_o;
        case (rd_state)
            R_IDLE:  if (ar_hs) rd_next = R_DATA;
            default: if (s_axilite_rready_i) rd_next = R_IDLE;
        endcase
    end

    // Zero-extend the register to the 32-bit read bus
    always_comb begin
        rd_ext                   = '0;
        rd_ext[NUM_GPIO_OUT-1:0] = gpio_q;
    end

    // Capture read data at the AR handshake; it sees the pre-update register
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_hs) begin
            if (s_axilite_araddr_i[3:2] == SEL_NONE) begin
                rdata_q <= '0;
                rresp_q <= RESP_SLVERR;
            end else begin
                rdata_q <= rd_ext;
                rresp_q <= RESP_OKAY;
            end
        end
    end

    assign s_axilite_bresp_o = bresp_q;
    assign s_axilite_rdata_o = rdata_q;
    assign s_axilite_rresp_o = rresp_q;
    assign gpio_o            = gpio_q;

endmodule
